// File: rtl/aia_pkg.sv
// aia_pkg: shared IMSIC interrupt-file types, default sizes and word-count helper
package aia_pkg;

    localparam int unsigned UserNrVSIntpFiles  = 4;
    localparam int unsigned UserNrSourcesImsic = 64;

    typedef enum logic [2:0] {
        SET_EIE,
        CLR_EIE,
        SET_EIP,
        CLR_EIP,
        WR_THRESH,
        WR_DELIV,
        CLAIM
    } imsic_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_e;

    function automatic int unsigned nr_words(input int unsigned nr_sources);
        return nr_sources / 64;
    endfunction

endpackage

// File: rtl/aia_imsic_word_scan.sv
// aia_imsic_word_scan: lowest-set-bit finder over one 64-bit word, gated by threshold
module aia_imsic_word_scan #(
    parameter int unsigned ID_W = 6,
    parameter int unsigned WI_W = 1
) (
    input  logic [63:0]     word_i,
    input  logic [WI_W-1:0] base_i,
    input  logic [ID_W-1:0] thresh_i,
    output logic            hit_o,
    output logic [ID_W-1:0] id_o
);

    logic [5:0] bit_idx;
    logic       any;

    // downward sweep so the final assignment is the lowest set bit
    always_comb begin
        bit_idx = '0;
        any     = 1'b0;
        for (int i = 63; i >= 0; i--)
            if (word_i[i]) begin
                bit_idx = 6'(i);
                any     = 1'b1;
            end
        id_o  = ID_W'({base_i, bit_idx});
        hit_o = any && (thresh_i == '0 || id_o < thresh_i);
    end

endmodule

// File: rtl/aia_imsic_intp_files.sv
// aia_imsic_intp_files: IMSIC M/S/VS interrupt-file bank with sequential topei scanner
// Optional per-file MSI counter output msi_cnt_o enabled by AIA_IMSIC_MSI_COUNT_EN.
module aia_imsic_intp_files
    import aia_pkg::*;
#(
    parameter  int unsigned NR_VS_FILES = UserNrVSIntpFiles,
    parameter  int unsigned NR_SOURCES  = UserNrSourcesImsic,
    localparam int unsigned NR_FILES    = 2 + NR_VS_FILES,
    localparam int unsigned ID_W        = $clog2(NR_SOURCES),
    localparam int unsigned FILE_W      = (NR_FILES > 1) ? $clog2(NR_FILES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       msi_valid_i,
    output logic                       msi_ready_o,
    input  logic [FILE_W-1:0]          msi_file_i,
    input  logic [ID_W-1:0]            msi_id_i,
    input  logic                       csr_valid_i,
    input  logic [FILE_W-1:0]          csr_file_i,
    input  logic [2:0]                 csr_op_i,
    input  logic [ID_W-1:0]            csr_id_i,
    input  logic                       csr_wdata_i,
    output logic [NR_FILES*ID_W-1:0]   topei_o,
    output logic [NR_FILES-1:0]        eip_o,
    output logic                       scan_busy_o
`ifdef AIA_IMSIC_MSI_COUNT_EN
    ,output logic [NR_FILES*16-1:0]    msi_cnt_o
`endif
);

    localparam int unsigned NW   = nr_words(NR_SOURCES);
    localparam int unsigned WI_W = (NW > 1) ? $clog2(NW) : 1;

    logic [NR_FILES-1:0][NR_SOURCES-1:0] eip, eie;
    logic [NR_FILES-1:0][ID_W-1:0]       thresh, topei;
    logic [NR_FILES-1:0]                 deliv, dirty, dirty_set, dirty_clr, msi_hit, csr_hit;
    logic                                rdy_q, msi_acc, hit;
    scan_state_e                         state;
    logic [FILE_W-1:0]                   cur, pick;
    logic [WI_W-1:0]                     word;
    logic [ID_W-1:0]                     best, hit_id;
    logic [NW-1:0][63:0]                 cur_eip, cur_eie;
    logic [63:0]                         masked;

    // a CLAIM on the MSI's target file stalls the MSI so the claim sees stable state
    assign msi_ready_o = rdy_q && !(csr_valid_i && csr_op_i == CLAIM && csr_file_i == msi_file_i);
    assign msi_acc     = msi_valid_i && msi_ready_o;
    assign scan_busy_o = state != IDLE;
    assign topei_o     = topei;

    // per-file decode of CSR and MSI requests; out-of-range files match nothing
    always_comb begin
        for (int f = 0; f < NR_FILES; f++) begin
            csr_hit[f]   = csr_valid_i && csr_file_i == FILE_W'(f);
            msi_hit[f]   = msi_acc && msi_file_i == FILE_W'(f) && msi_id_i != '0;
            dirty_set[f] = (csr_hit[f] && csr_op_i != WR_DELIV) || msi_hit[f];
            eip_o[f]     = deliv[f] && topei[f] != '0;
        end
    end

    // scanner file pick, dirty consumption and current masked word
    always_comb begin
        pick = '0;
        for (int f = int'(NR_FILES) - 1; f >= 0; f--)
            if (dirty[f]) pick = FILE_W'(f);
        dirty_clr = '0;
        if (state == IDLE && |dirty) dirty_clr[pick] = 1'b1;
        if (state == SCAN && dirty[cur]) dirty_clr[cur] = 1'b1;
        cur_eip = eip[cur];
        cur_eie = eie[cur];
        masked  = cur_eip[word] & cur_eie[word] & ~64'(word == '0);
    end

    aia_imsic_word_scan #(
        .ID_W (ID_W),
        .WI_W (WI_W)
    ) i_word_scan (
        .word_i   (masked),
        .base_i   (word),
        .thresh_i (thresh[cur]),
        .hit_o    (hit),
        .id_o     (hit_id)
    );

    // scanner FSM: one word per cycle, restart when the file is touched mid-scan
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cur   <= '0;
            word  <= '0;
            best  <= '0;
        end else begin
            case (state)
                IDLE: if (|dirty) begin
                    state <= SCAN;
                    cur   <= pick;
                    word  <= '0;
                    best  <= '0;
                end
                SCAN: if (dirty[cur]) word <= '0;
                    else if (hit) begin
                        best  <= hit_id;
                        state <= DONE;
                    end
                    else if (word == WI_W'(NW - 1)) state <= DONE;
                    else word <= word + WI_W'(1);
                default: state <= IDLE;
            endcase
        end
    end

    // file registers; MSI set is applied last so it beats a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eip    <= '0;
            eie    <= '0;
            thresh <= '0;
            deliv  <= '0;
            topei  <= '0;
            dirty  <= '1;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            if (state == DONE) topei[cur] <= best;
            for (int f = 0; f < NR_FILES; f++) begin
                if (csr_hit[f]) begin
                    case (csr_op_i)
                        SET_EIE:   eie[f][csr_id_i] <= 1'b1;
                        CLR_EIE:   eie[f][csr_id_i] <= 1'b0;
                        SET_EIP:   if (csr_id_i != '0) eip[f][csr_id_i] <= 1'b1;
                        CLR_EIP:   eip[f][csr_id_i] <= 1'b0;
                        WR_THRESH: thresh[f] <= csr_id_i;
                        WR_DELIV:  deliv[f] <= csr_wdata_i;
                        CLAIM: begin
                            if (topei[f] != '0) eip[f][topei[f]] <= 1'b0;
                            topei[f] <= '0;
                        end
                        default: ;
                    endcase
                end
                if (msi_hit[f]) eip[f][msi_id_i] <= 1'b1;
            end
        end
    end

`ifdef AIA_IMSIC_MSI_COUNT_EN
    logic [NR_FILES-1:0][15:0] cnt;

    assign msi_cnt_o = cnt;

    // saturating count of accepted MSIs carrying a real file and nonzero id
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt <= '0;
        else
            for (int f = 0; f < NR_FILES; f++)
                if (msi_hit[f] && cnt[f] != 16'hFFFF) cnt[f] <= cnt[f] + 16'd1;
    end
`endif

endmodule

// File: tb/tb_aia_imsic_intp_files.sv
// tb_aia_imsic_intp_files: directed scoreboard bench for the IMSIC file bank (256 sources, 6 files)
module tb_aia_imsic_intp_files;
    import aia_pkg::*;

    localparam int NF = 6;
    localparam int IW = 8;
    localparam int FW = 3;

    typedef struct {
        int             f;
        logic [IW-1:0]  top;
        logic           e;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            msi_valid = 1'b0;
    logic [FW-1:0]   msi_file = '0;
    logic [IW-1:0]   msi_id = '0;
    logic            csr_valid = 1'b0;
    logic [FW-1:0]   csr_file = '0;
    logic [2:0]      csr_op = '0;
    logic [IW-1:0]   csr_id = '0;
    logic            csr_wdata = 1'b0;
    logic            msi_ready;
    logic [NF*IW-1:0] topei;
    logic [NF-1:0]   eip;
    logic            busy;
`ifdef AIA_IMSIC_MSI_COUNT_EN
    logic [NF*16-1:0] cnt;
`endif

    int            tests = 0;
    int            fails = 0;
    exp_t          q[$];
    logic [IW-1:0] exp_top [NF];
    logic          exp_dlv [NF];
    int            exp_cnt [NF];

    aia_imsic_intp_files #(
        .NR_VS_FILES (4),
        .NR_SOURCES  (256)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .msi_valid_i (msi_valid),
        .msi_ready_o (msi_ready),
        .msi_file_i  (msi_file),
        .msi_id_i    (msi_id),
        .csr_valid_i (csr_valid),
        .csr_file_i  (csr_file),
        .csr_op_i    (csr_op),
        .csr_id_i    (csr_id),
        .csr_wdata_i (csr_wdata),
        .topei_o     (topei),
        .eip_o       (eip),
        .scan_busy_o (busy)
`ifdef AIA_IMSIC_MSI_COUNT_EN
        ,.msi_cnt_o  (cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic cv, input int cf, input imsic_op_e op, input int cid, input logic wd,
                       input logic mv, input int mf, input int mid);
        @(negedge clk);
        csr_valid = cv; csr_file = FW'(cf); csr_op = op; csr_id = IW'(cid); csr_wdata = wd;
        msi_valid = mv; msi_file = FW'(mf); msi_id = IW'(mid);
        if (mv && !(cv && op == CLAIM && cf == mf) && mf < NF && mid != 0) exp_cnt[mf]++;
        @(negedge clk);
        csr_valid = 1'b0; msi_valid = 1'b0;
    endtask

    task automatic csr(input int f, input imsic_op_e op, input int id, input logic wd);
        cyc(1'b1, f, op, id, wd, 1'b0, 0, 0);
    endtask

    task automatic msi(input int f, input int id);
        cyc(1'b0, 0, SET_EIE, 0, 1'b0, 1'b1, f, id);
    endtask

    task automatic expect_f(input int f, input int v);
        exp_top[f] = IW'(v);
        q.push_back('{f, IW'(v), exp_dlv[f] && v != 0});
    endtask

    task automatic settle_check(input string tag);
        int quiet;
        int n;
        exp_t e;
        logic [NF*IW-1:0] all_top;
        logic [NF-1:0] all_eip;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < 400) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        chk({tag, " settle"}, 64'(quiet >= 3), 64'd1);
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("%s topei[%0d]", tag, e.f), 64'(topei[e.f*IW +: IW]), 64'(e.top));
            chk($sformatf("%s eip[%0d]", tag, e.f), 64'(eip[e.f]), 64'(e.e));
        end
        for (int f = 0; f < NF; f++) begin
            all_top[f*IW +: IW] = exp_top[f];
            all_eip[f] = exp_dlv[f] && exp_top[f] != '0;
        end
        chk({tag, " topei_all"}, 64'(topei), 64'(all_top));
        chk({tag, " eip_all"}, 64'(eip), 64'(all_eip));
    endtask

    initial begin
        int n;
        for (int f = 0; f < NF; f++) begin
            exp_top[f] = '0;
            exp_dlv[f] = 1'b0;
            exp_cnt[f] = 0;
        end

        repeat (3) @(negedge clk);
        chk("rst ready", 64'(msi_ready), 64'd0);
        chk("rst topei", 64'(topei), 64'd0);
        chk("rst eip", 64'(eip), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
`ifdef AIA_IMSIC_MSI_COUNT_EN
        chk("rst cnt", 64'(cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release ready", 64'(msi_ready), 64'd1);
        chk("release busy", 64'(busy), 64'd1);
        settle_check("post_reset");

        csr(1, SET_EIE, 5, 1'b0);
        settle_check("eie1");
        @(negedge clk);
        msi_valid = 1'b1; msi_file = 3'd1; msi_id = 8'd5;
        exp_cnt[1]++;
        @(negedge clk);
        msi_valid = 1'b0;
        n = 0;
        while (topei[IW +: IW] !== 8'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency word0", 64'(n), 64'd3);
        exp_top[1] = 8'd5;
        chk("eip1 no deliv", 64'(eip[1]), 64'd0);
        csr(1, WR_DELIV, 0, 1'b1);
        exp_dlv[1] = 1'b1;
        chk("eip1 deliv", 64'(eip[1]), 64'd1);
        expect_f(1, 5);
        settle_check("deliv1");

        csr(0, SET_EIE, 3, 1'b0);
        csr(0, SET_EIE, 200, 1'b0);
        msi(0, 3);
        msi(0, 200);
        expect_f(0, 3);
        settle_check("f0 two");
        csr(0, CLAIM, 0, 1'b0);
        chk("claim zero", 64'(topei[0 +: IW]), 64'd0);
        n = 0;
        while (topei[0 +: IW] !== 8'd200 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("latency word3", 64'(n), 64'd6);
        expect_f(0, 200);
        settle_check("f0 rescan");

        csr(2, SET_EIE, 12, 1'b0);
        csr(2, SET_EIE, 15, 1'b0);
        csr(2, WR_DELIV, 0, 1'b1);
        exp_dlv[2] = 1'b1;
        csr(2, WR_THRESH, 10, 1'b0);
        msi(2, 12);
        msi(2, 15);
        expect_f(2, 0);
        settle_check("thr10");
        csr(2, WR_THRESH, 0, 1'b0);
        expect_f(2, 12);
        settle_check("thr0");
        csr(2, WR_THRESH, 12, 1'b0);
        expect_f(2, 0);
        settle_check("thr12");
        csr(2, WR_THRESH, 13, 1'b0);
        expect_f(2, 12);
        settle_check("thr13");

        csr(0, SET_EIE, 100, 1'b0);
        expect_f(0, 200);
        settle_check("eie100");
        @(negedge clk);
        csr_valid = 1'b1; csr_file = 3'd0; csr_op = CLAIM; csr_id = '0;
        msi_valid = 1'b1; msi_file = 3'd0; msi_id = 8'd100;
        #1 chk("ready claim", 64'(msi_ready), 64'd0);
        @(negedge clk);
        csr_valid = 1'b0;
        #1 chk("ready after claim", 64'(msi_ready), 64'd1);
        @(negedge clk);
        msi_valid = 1'b0;
        exp_cnt[0]++;
        expect_f(0, 100);
        settle_check("claim msi");
        @(negedge clk);
        csr_valid = 1'b1; csr_file = 3'd4; csr_op = CLAIM; msi_file = 3'd0;
        #1 chk("ready other file", 64'(msi_ready), 64'd1);
        @(negedge clk);
        csr_valid = 1'b0;
        csr(0, CLAIM, 0, 1'b0);
        expect_f(0, 0);
        settle_check("claim last");

        csr(3, SET_EIE, 7, 1'b0);
        csr(3, WR_DELIV, 0, 1'b1);
        exp_dlv[3] = 1'b1;
        msi(3, 7);
        expect_f(3, 7);
        settle_check("f3 set");
        cyc(1'b1, 3, CLR_EIP, 7, 1'b0, 1'b1, 3, 7);
        expect_f(3, 7);
        settle_check("set wins");
        csr(3, CLR_EIP, 7, 1'b0);
        expect_f(3, 0);
        settle_check("clr eip");
        @(negedge clk);
        msi_valid = 1'b1; msi_file = 3'd3; msi_id = 8'd0;
        #1 chk("ready id0", 64'(msi_ready), 64'd1);
        @(negedge clk);
        msi_file = 3'd7; msi_id = 8'd9;
        #1 chk("ready file7", 64'(msi_ready), 64'd1);
        @(negedge clk);
        msi_valid = 1'b0;
        expect_f(3, 0);
        settle_check("bad msi");

        csr(4, SET_EIE, 20, 1'b0);
        csr(4, SET_EIP, 0, 1'b0);
        csr(4, SET_EIP, 20, 1'b0);
        expect_f(4, 20);
        settle_check("set eip");
        csr(4, CLR_EIE, 20, 1'b0);
        expect_f(4, 0);
        settle_check("clr eie");
        csr(5, SET_EIE, 255, 1'b0);
        msi(5, 255);
        expect_f(5, 255);
        settle_check("id max");

`ifdef AIA_IMSIC_MSI_COUNT_EN
        for (int f = 0; f < NF; f++)
            chk($sformatf("cnt[%0d]", f), 64'(cnt[f*16 +: 16]), 64'(exp_cnt[f]));
        @(negedge clk);
        msi_valid = 1'b1; msi_file = 3'd1; msi_id = 8'd5;
        repeat (65537) @(negedge clk);
        msi_valid = 1'b0;
        exp_cnt[1] += 65537;
        chk("cnt sat", 64'(cnt[16 +: 16]), 64'((exp_cnt[1] > 65535) ? 65535 : exp_cnt[1]));
        chk("cnt other", 64'(cnt[0 +: 16]), 64'(exp_cnt[0]));
        settle_check("after sat");
`endif

        msi(1, 5);
        @(negedge clk);
        chk("mid scan busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2 topei", 64'(topei), 64'd0);
        chk("rst2 eip", 64'(eip), 64'd0);
        chk("rst2 busy", 64'(busy), 64'd0);
        chk("rst2 ready", 64'(msi_ready), 64'd0);
`ifdef AIA_IMSIC_MSI_COUNT_EN
        chk("rst2 cnt", 64'(cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < NF; f++) begin
            exp_top[f] = '0;
            exp_dlv[f] = 1'b0;
        end
        settle_check("post_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
